motor_drive_ctrl: RTL and testbench

- Command-to-drive stage for a single brushed DC motor; sits directly upstream of the H-bridge pin-split stage and produces its 3-bit drive word.
- Accepts a signed speed command or a brake request over a valid/ready handshake.
- Generates a prescaled PWM, direction lines, and an enforced coast dead-time on every direction reversal, so the bridge never switches legs directly.

---
 rtl/motor_drive_ctrl.sv | 138 +++++++++++++
 tb/tb_motor_drive_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_drive_ctrl.sv
// Command-to-drive stage for one brushed DC motor: prescaled PWM, direction legs,
// brake, and a forced coast interval whenever the driven direction reverses.
module motor_drive_ctrl #(
    parameter int CMD_W    = 8,
    parameter int PRESCALE = 4,
    parameter int DEAD_CYC = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [CMD_W-1:0] cmd_speed_i,
    input  logic             cmd_brake_i,
    output logic [2:0]       drv_o,
    output logic             busy_o,
    output logic             period_tick_o
);

    localparam int DW  = CMD_W - 1;
    localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DCW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    localparam logic [DW-1:0]  CNT_TOP    = DW'(2**DW - 2);
    localparam logic [DW-1:0]  MAG_MAX    = DW'(2**DW - 1);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [DCW-1:0] DEAD_INIT  = DCW'(DEAD_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BRAKE, ST_DEAD} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_FWD, DIR_REV} dir_t;

    state_t         state_q;
    dir_t           dir_q, tgt_dir_q, pend_dir_q, pend_dir_d;
    logic [PW-1:0]  presc_q;
    logic [DW-1:0]  cnt_q, duty_q, tgt_duty_q, pend_duty_q, pend_duty_d;
    logic [DCW-1:0] dead_q;
    logic           pend_full_q, pend_brake_q;
    logic [2:0]     drv_q;
    logic           tick_q;

    logic step, tick, dead_done, consume, accept;

    // -128 has no positive twin in CMD_W bits, so it saturates to the full-scale duty.
    function automatic logic [DW-1:0] sat_mag(input logic [CMD_W-1:0] s);
        logic [CMD_W-1:0] a;
        a = s[CMD_W-1] ? (~s + CMD_W'(1)) : s;
        return a[CMD_W-1] ? MAG_MAX : a[DW-1:0];
    endfunction

    assign step      = (presc_q == PRESC_LAST);
    assign tick      = step && (cnt_q == CNT_TOP);
    assign dead_done = (state_q == ST_DEAD) && (dead_q == '0);
    assign consume   = pend_full_q && ((tick && state_q != ST_DEAD) || dead_done);
    assign accept    = cmd_valid_i && !pend_full_q;

    assign pend_duty_d = sat_mag(cmd_speed_i);
    assign pend_dir_d  = (cmd_speed_i == '0) ? DIR_NONE :
                         (cmd_speed_i[CMD_W-1] ? DIR_REV : DIR_FWD);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_NONE;
            tgt_dir_q    <= DIR_NONE;
            pend_dir_q   <= DIR_NONE;
            presc_q      <= '0;
            cnt_q        <= '0;
            duty_q       <= '0;
            tgt_duty_q   <= '0;
            pend_duty_q  <= '0;
            dead_q       <= '0;
            pend_full_q  <= 1'b0;
            pend_brake_q <= 1'b0;
            drv_q        <= 3'b000;
            tick_q       <= 1'b0;
        end else begin
            tick_q <= tick;
            if (step) begin
                presc_q <= '0;
                cnt_q   <= (cnt_q == CNT_TOP) ? '0 : cnt_q + DW'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
            if (state_q == ST_DEAD && dead_q != '0)
                dead_q <= dead_q - DCW'(1);

            case (state_q)
                ST_RUN:   drv_q <= {cnt_q < duty_q, dir_q == DIR_REV, dir_q == DIR_FWD};
                ST_BRAKE: drv_q <= 3'b111;
                default:  drv_q <= 3'b000;
            endcase

            // A reversal is judged against the leg last driven, which dir_q keeps through DEAD.
            if (consume) begin
                if (pend_brake_q) begin
                    state_q <= ST_BRAKE;
                    dir_q   <= DIR_NONE;
                end else if (pend_dir_q == DIR_NONE) begin
                    state_q <= ST_IDLE;
                    dir_q   <= DIR_NONE;
                end else if ((state_q == ST_RUN || state_q == ST_DEAD) && pend_dir_q != dir_q) begin
                    state_q    <= ST_DEAD;
                    tgt_duty_q <= pend_duty_q;
                    tgt_dir_q  <= pend_dir_q;
                    dead_q     <= DEAD_INIT;
                end else begin
                    state_q <= ST_RUN;
                    duty_q  <= pend_duty_q;
                    dir_q   <= pend_dir_q;
                    if (state_q == ST_DEAD) begin
                        presc_q <= '0;
                        cnt_q   <= '0;
                    end
                end
            end else if (dead_done) begin
                state_q <= ST_RUN;
                duty_q  <= tgt_duty_q;
                dir_q   <= tgt_dir_q;
                presc_q <= '0;
                cnt_q   <= '0;
            end

            if (consume)
                pend_full_q <= 1'b0;
            if (accept) begin
                pend_full_q  <= 1'b1;
                pend_brake_q <= cmd_brake_i;
                pend_duty_q  <= pend_duty_d;
                pend_dir_q   <= pend_dir_d;
            end
        end
    end

    assign cmd_ready_o   = !pend_full_q;
    assign busy_o        = (state_q == ST_DEAD) || pend_full_q;
    assign drv_o         = drv_q;
    assign period_tick_o = tick_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Scoreboard bench for motor_drive_ctrl: expected per-period drive profiles are queued
// when a command is issued and compared against a measured PWM period.
module tb_motor_drive_ctrl;

    localparam int PERIOD_CLK = 508;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_speed;
    logic       cmd_brake;
    logic [2:0] drv;
    logic       busy;
    logic       period_tick;

    typedef struct {
        string      tag;
        int         hi;
        logic [1:0] dir;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    motor_drive_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_speed_i  (cmd_speed),
        .cmd_brake_i  (cmd_brake),
        .drv_o        (drv),
        .busy_o       (busy),
        .period_tick_o(period_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Returns on the sample after the accepting edge.
    task automatic send_cmd(input int spd, input bit brk);
        int n = 0;
        @(negedge clk);
        cmd_speed = 8'(spd);
        cmd_brake = brk;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check_eq("send_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_brake = 1'b0;
    endtask

    task automatic wait_tick(output int zeros);
        int n = 0;
        zeros = 0;
        do begin
            @(negedge clk);
            n++;
            if (drv == 3'b000) zeros++;
        end while (!period_tick && n < 1500);
        if (!period_tick) check_eq("tick_timeout", 0, 1);
    endtask

    task automatic wait_zero(input string tag);
        int n = 0;
        while (drv != 3'b000 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        if (drv != 3'b000) check_eq({tag, "_zero_timeout"}, 0, 1);
    endtask

    // Any full-period window of a steady PWM holds duty*PRESCALE high samples.
    task automatic measure_pop();
        exp_t e;
        int hi = 0;
        int bad_dir = 0;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < PERIOD_CLK; i++) begin
            if (i > 0) @(negedge clk);
            if (drv[2]) hi++;
            if (drv[1:0] != e.dir) bad_dir++;
        end
        check_eq({e.tag, "_hi"}, hi, e.hi);
        check_eq({e.tag, "_dir_err"}, bad_dir, 0);
    endtask

    task automatic apply(input int spd, input bit brk, input int exp_hi,
                         input logic [1:0] exp_dir, input string tag, input bit no_dead);
        int z1, z2;
        send_cmd(spd, brk);
        sb.push_back('{tag, exp_hi, exp_dir});
        check_eq({tag, "_acc_rdy"}, int'(cmd_ready), 0);
        check_eq({tag, "_acc_busy"}, int'(busy), 1);
        wait_tick(z1);
        check_eq({tag, "_cons_rdy"}, int'(cmd_ready), 1);
        check_eq({tag, "_cons_busy"}, int'(busy), 0);
        wait_tick(z2);
        if (no_dead) check_eq({tag, "_no_dead"}, z1 + z2, 0);
        measure_pop();
    endtask

    initial begin
        int z, len, n, nz;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_speed = '0;
        cmd_brake = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_drv", int'(drv), 0);
        check_eq("rst_rdy", int'(cmd_ready), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_tick", int'(period_tick), 0);
        rst = 1'b0;

        apply(64, 1'b0, 256, 2'b01, "fwd64", 1'b0);

        // Reversal: exact coast length, then a full-length first period.
        send_cmd(-32, 1'b0);
        sb.push_back('{"rev32", 128, 2'b10});
        wait_zero("rev32");
        z = 0;
        while (drv == 3'b000 && z < 100) begin
            z++;
            if (z == 8) check_eq("dead_busy", int'(busy), 1);
            @(negedge clk);
        end
        check_eq("dead_len", z, 16);
        check_eq("dead_exit_drv", int'(drv), 3'b110);
        len = 1;
        while (!period_tick && len < 1000) begin
            @(negedge clk);
            len++;
        end
        check_eq("first_period_len", len, PERIOD_CLK);
        measure_pop();

        apply(-128, 1'b0, 508, 2'b10, "rev127", 1'b0);
        apply(0, 1'b0, 0, 2'b00, "idle", 1'b0);
        apply(64, 1'b0, 256, 2'b01, "fwd64b", 1'b0);
        apply(-50, 1'b1, 508, 2'b11, "brake", 1'b0);
        apply(10, 1'b0, 40, 2'b01, "fwd10", 1'b1);

        // Command accepted during DEAD, a second one stalled until expiry.
        send_cmd(-64, 1'b0);
        wait_zero("dead2");
        send_cmd(100, 1'b0);
        check_eq("dead_pend_rdy", int'(cmd_ready), 0);
        @(negedge clk);
        cmd_speed = 8'(-20);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("stall_seen", int'(n > 0), 1);
        check_eq("expiry_drv_coast", int'(drv), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("dead_exit_fwd", int'(drv), 3'b101);
        check_eq("second_acc_rdy", int'(cmd_ready), 0);
        sb.push_back('{"fwd100", 400, 2'b01});
        measure_pop();
        sb.push_back('{"rev20", 80, 2'b10});
        wait_tick(z);
        measure_pop();

        // Reset in the middle of DEAD with a command pending.
        send_cmd(30, 1'b0);
        wait_zero("dead3");
        send_cmd(-40, 1'b0);
        check_eq("dead3_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_drv", int'(drv), 0);
        check_eq("mid_rst_rdy", int'(cmd_ready), 1);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_tick", int'(period_tick), 0);
        len = 0;
        nz  = 0;
        do begin
            @(negedge clk);
            len++;
            if (drv != 3'b000) nz++;
        end while (!period_tick && len < 1000);
        check_eq("post_rst_tick_gap", len, PERIOD_CLK);
        check_eq("post_rst_drv_active", nz, 0);
        check_eq("sb_left", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
